instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types: FSM state codes, fetch-buffer entry layout, NOP encoding.
// Also provides a word-alignment helper for fetch addresses.
package fetch_pkg;

  typedef logic [1:0] fetch_state_e;

  localparam fetch_state_e ST_IDLE = 2'd0;
  localparam fetch_state_e ST_REQ  = 2'd1;
  localparam fetch_state_e ST_WAIT = 2'd2;
  localparam fetch_state_e ST_DROP = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer FIFO of BUF_DEPTH entries; a push is visible at the head the next cycle, flush empties it.
// No internal backpressure: pushes when full and pops when empty are ignored, flush wins over both.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  fetch_entry_t                   push_dat,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   head_dat,
  output logic [$clog2(BUF_DEPTH+1)-1:0] count,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(BUF_DEPTH - 1);

  fetch_entry_t  mem [BUF_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(BUF_DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap explicitly so non-power-of-two depths work.
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch with one outstanding imem read feeding a BUF_DEPTH buffer to IF/ID (optional FETCH_PERF_CNT_EN counters).
// Words reach the outputs 1 cycle after imem_rvalid; stall holds the head, fetch idles while the buffer is full.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        valid_IF_IFID,
  output logic [31:0] instruction_IF_IFID,
  output logic [31:0] PC_IF_IFID
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_e  state;
  fetch_state_e  state_d;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_d;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          room;
  fetch_entry_t  head_dat;
  fetch_entry_t  push_dat;

  // Gated with rst_n so no request is visible while reset is held.
  assign imem_req    = rst_n && (state == ST_REQ);
  assign imem_addr   = fetch_pc;
  assign pop         = !empty && !stall;
  assign push        = (state == ST_WAIT) && imem_rvalid && !redirect && !full;
  assign push_dat    = '{pc: fetch_pc - 32'd4, instr: imem_rdata};
  assign count_after = count + CW'(push) - CW'(pop);
  assign room        = count_after < CW'(BUF_DEPTH);

  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      case (state)
        // An in-flight read must still be swallowed unless it lands this very cycle.
        ST_WAIT, ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
        ST_REQ:           state_d = imem_gnt ? ST_DROP : ST_REQ;
        default:          state_d = ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_gnt) begin
            fetch_pc_d = fetch_pc + 32'd4;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: if (imem_rvalid) state_d = room ? ST_REQ : ST_IDLE;
        ST_IDLE: if (room) state_d = ST_REQ;
        ST_DROP: if (imem_rvalid) state_d = ST_REQ;
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
    end
  end

  fetch_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect),
    .head_dat (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign valid_IF_IFID       = !empty;
  assign instruction_IF_IFID = empty ? NOP_INSTR : head_dat.instr;
  assign PC_IF_IFID          = empty ? 32'h0000_0000 : head_dat.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (push && (perf_fetch_cnt != '1))        perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
      if (redirect && (perf_redirect_cnt != '1)) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every cycle, plus directed literal scenarios.
module tb_instr_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid_IF_IFID;
  logic [31:0] instruction_IF_IFID;
  logic [31:0] PC_IF_IFID;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  instr_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt      (perf_fetch_cnt),
    .perf_redirect_cnt   (perf_redirect_cnt),
`endif
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_gnt            (imem_gnt),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .stall               (stall),
    .valid_IF_IFID       (valid_IF_IFID),
    .instruction_IF_IFID (instruction_IF_IFID),
    .PC_IF_IFID          (PC_IF_IFID)
  );

  always #5 clk = ~clk;

  // Reference model: buffer contents, next fetch address, one in-flight read and whether it is doomed.
  ent_t        mq[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_addr;

  // Memory responder.
  bit          r_pend;
  int          r_cnt;
  logic [31:0] r_addr;
  int          lat_min;
  int          lat_max;
  bit          spur_en;

  int          n_tests;
  int          n_fail;
  logic [31:0] seen[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic exp_req = rst_n && !m_out && (mq.size() < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("valid", 32'(valid_IF_IFID), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("instr", instruction_IF_IFID, mq[0].instr);
      chk("pc", PC_IF_IFID, mq[0].pc);
    end else begin
      chk("instr_empty", instruction_IF_IFID, NOP);
      chk("pc_empty", PC_IF_IFID, 32'h0);
    end
    if (valid_IF_IFID) seen.push_back(PC_IF_IFID);
  endtask

  // Advances the model over the coming clock edge using the inputs just driven.
  task automatic model_step();
    bit   req_e = !m_out && (mq.size() < DEPTH);
    bit   acc   = req_e && imem_gnt;
    ent_t e;
    if (redirect) begin
      mq.delete();
      if (m_out && imem_rvalid) begin
        m_out  = 0;
        m_drop = 0;
      end else if (m_out) begin
        m_drop = 1;
      end
      m_pc = {redirect_pc[31:2], 2'b00};
      if (acc) begin
        m_out  = 1;
        m_drop = 1;
      end
    end else begin
      if (mq.size() > 0 && !stall) void'(mq.pop_front());
      if (m_out && imem_rvalid) begin
        if (!m_drop) begin
          e.pc    = m_addr;
          e.instr = imem_rdata;
          mq.push_back(e);
        end
        m_out  = 0;
        m_drop = 0;
      end
      if (acc) begin
        m_out  = 1;
        m_drop = 0;
        m_addr = m_pc;
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit g, input bit s, input bit r, input logic [31:0] rpc);
    check_all();
    imem_gnt    = g;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (r_pend) begin
      if (r_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(r_addr);
        r_pend      = 0;
      end else begin
        r_cnt--;
      end
    end else if (spur_en && $urandom_range(15, 0) == 0) begin
      imem_rvalid = 1'b1;
    end
    model_step();
    if (imem_req && g) begin
      r_pend = 1;
      r_addr = imem_addr;
      r_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit keep_resp);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(valid_IF_IFID), 32'd0);
    chk("rst_instr", instruction_IF_IFID, NOP);
    chk("rst_pc", PC_IF_IFID, 32'h0);
    mq.delete();
    m_out  = 0;
    m_drop = 0;
    m_pc   = RST_PC;
    if (!keep_resp) r_pend = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, RST_PC);
  endtask

  initial begin
    logic [31:0] rpc;
    int          sp;
    n_tests = 0;
    n_fail  = 0;
    r_pend  = 0;
    spur_en = 0;
    lat_min = 1;
    lat_max = 1;
    rst_n   = 1'b0;
    @(negedge clk);

    // Streaming: PCs 0,4,8 on consecutive valid outputs.
    do_reset(0);
    seen.delete();
    repeat (10) cycle(1, 0, 0, 32'h0);
    chk("stream_len", 32'(seen.size() >= 3), 32'd1);
    if (seen.size() >= 3) begin
      chk("stream_pc0", seen[0], 32'h0);
      chk("stream_pc1", seen[1], 32'h4);
      chk("stream_pc2", seen[2], 32'h8);
    end

    // Stall held fills the buffer and idles fetch.
    do_reset(0);
    repeat (10) cycle(1, 1, 0, 32'h0);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(valid_IF_IFID), 32'd1);
    chk("full_pc", PC_IF_IFID, 32'h0);
    cycle(1, 0, 0, 32'h0);
    chk("drain_pc", PC_IF_IFID, 32'h4);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h8);

    // Redirect while a read is in flight.
    do_reset(0);
    lat_min = 2;
    lat_max = 2;
    cycle(1, 0, 0, 32'h0);
    cycle(0, 0, 1, 32'h0000_0103);
    cycle(0, 0, 0, 32'h0);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", imem_addr, 32'h0000_0100);
    chk("drop_valid", 32'(valid_IF_IFID), 32'd0);
    seen.delete();
    repeat (8) cycle(1, 0, 0, 32'h0);
    chk("drop_len", 32'(seen.size() > 0), 32'd1);
    if (seen.size() > 0) chk("drop_first_pc", seen[0], 32'h0000_0100);

    // Redirect coinciding with the response.
    do_reset(0);
    lat_min = 1;
    lat_max = 1;
    cycle(1, 0, 0, 32'h0);
    cycle(0, 0, 1, 32'h0000_0200);
    chk("same_valid", 32'(valid_IF_IFID), 32'd0);
    chk("same_addr", imem_addr, 32'h0000_0200);

    // Grant withheld: request and outputs frozen.
    cycle(1, 1, 0, 32'h0);
    cycle(0, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", imem_addr, 32'h0000_0204);
      chk("hold_pc", PC_IF_IFID, 32'h0000_0200);
      cycle(0, 1, 0, 32'h0);
    end

    // Fetch address wraps past the top of memory.
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_pc", PC_IF_IFID, 32'hFFFF_FFFC);

    // Reset mid-transaction: the stale response must be ignored.
    do_reset(0);
    lat_min = 3;
    lat_max = 3;
    cycle(1, 0, 0, 32'h0);
    do_reset(1);
    repeat (4) cycle(0, 0, 0, 32'h0);
    chk("stale_valid", 32'(valid_IF_IFID), 32'd0);
    chk("stale_addr", imem_addr, RST_PC);

    // Randomized traffic with varying stall pressure.
    lat_min = 1;
    lat_max = 3;
    spur_en = 1;
    for (int ph = 0; ph < 12; ph++) begin
      sp = (ph % 3 == 0) ? 0 : ((ph % 3 == 1) ? 30 : 90);
      repeat (250) begin
        rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        cycle($urandom_range(99, 0) < 70, $urandom_range(99, 0) < sp,
              $urandom_range(99, 0) < 4, rpc);
      end
      if (ph == 5) do_reset(0);
    end
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
